// File: rtl/loop_ctrl.sv
// Counted-loop controller: runs i from 0 up to a latched bound, handing each iteration to a body via valid/ready.
// Define LOOP_CTRL_STEP_EN to add a runtime step port; without it the step is fixed at 1.
module loop_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] bound,
`ifdef LOOP_CTRL_STEP_EN
  input  logic [WIDTH-1:0] step,
`endif
  input  logic             body_ready,
  output logic [WIDTH-1:0] i,
  output logic             body_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    BODY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] i_nx;
  logic [WIDTH-1:0] iter_nx;
  logic [WIDTH-1:0] bound_q;
  logic [WIDTH-1:0] bound_nx;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH:0]   sum;

`ifdef LOOP_CTRL_STEP_EN
  logic [WIDTH-1:0] step_nx;
`else
  assign step_q = ONE;
`endif

  // The extra carry bit lets the loop exit instead of wrapping i past 2^WIDTH-1.
  assign sum = {1'b0, i} + {1'b0, step_q};

  always_comb begin
    state_nx = state;
    i_nx     = i;
    iter_nx  = iter_count;
    bound_nx = bound_q;
`ifdef LOOP_CTRL_STEP_EN
    step_nx  = step_q;
`endif
    case (state)
      IDLE: begin
        if (go) begin
          state_nx = INIT;
          bound_nx = bound;
          iter_nx  = '0;
`ifdef LOOP_CTRL_STEP_EN
          step_nx  = (step == '0) ? ONE : step;
`endif
        end
      end
      INIT: begin
        i_nx     = '0;
        state_nx = CHECK;
      end
      CHECK: begin
        state_nx = (i < bound_q) ? BODY : DONE;
      end
      BODY: begin
        if (body_ready) begin
          iter_nx = iter_count + ONE;
          if (sum[WIDTH]) begin
            state_nx = DONE;
          end else begin
            i_nx     = sum[WIDTH-1:0];
            state_nx = CHECK;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      i          <= '0;
      iter_count <= '0;
      bound_q    <= '0;
`ifdef LOOP_CTRL_STEP_EN
      step_q     <= '0;
`endif
    end else begin
      state      <= state_nx;
      i          <= i_nx;
      iter_count <= iter_nx;
      bound_q    <= bound_nx;
`ifdef LOOP_CTRL_STEP_EN
      step_q     <= step_nx;
`endif
    end
  end

  assign body_valid = (state == BODY);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

endmodule
